// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
// Parity helper is used only when UART_RX_PARITY_EN is defined.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_rx_state_e;

   localparam int UART_CLKS_PER_BIT_2M = 25;

   // Returns 1 when data plus received parity bit disagree with the chosen sense.
   function automatic logic parity_err_f(input logic [7:0] data, input logic par_bit,
                                         input logic odd);
      return (^data) ^ par_bit ^ odd;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus a falling-edge pulse.
// All flops reset to the idle-high line level.
module uart_rx_sync (
   input  logic clki,
   input  logic rst_n,
   input  logic i_rxd,
   output logic o_rxd_sync,
   output logic o_fall
);

   logic r_meta;
   logic r_sync;
   logic r_sync_d;

   // Synchronizer chain and one-cycle history for edge detection.
   always_ff @(posedge clki or negedge rst_n) begin
      if (!rst_n) begin
         r_meta   <= 1'b1;
         r_sync   <= 1'b1;
         r_sync_d <= 1'b1;
      end else begin
         r_meta   <= i_rxd;
         r_sync   <= r_meta;
         r_sync_d <= r_sync;
      end
   end

   assign o_rxd_sync = r_sync;
   assign o_fall     = r_sync_d & ~r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, LSB first, idle-high, oversampled on clki, valid/ready byte output.
// Optional parity stage enabled by defining UART_RX_PARITY_EN.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_2M,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_ODD   = 0
) (
   input  logic                 clki,
   input  logic                 rst_n,
   input  logic                 i_rxd,
   output logic [DATA_BITS-1:0] o_rx_data,
   output logic                 o_rx_valid,
   input  logic                 i_rx_ready,
   output logic                 o_rx_frame_err,
   output logic                 o_rx_parity_err,
   output logic                 o_rx_overrun,
   output logic                 o_rx_busy
);

   localparam int TW   = $clog2(CLKS_PER_BIT);
   localparam int BW   = $clog2(DATA_BITS);
   localparam int HALF = CLKS_PER_BIT / 2;
   localparam logic [TW-1:0] C_TICK_HALF = TW'(HALF - 1);
   localparam logic [TW-1:0] C_TICK_LAST = TW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] C_BIT_LAST  = BW'(DATA_BITS - 1);

   if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 8 || PARITY_ODD < 0 || PARITY_ODD > 1)
   begin : g_bad_cfg
      $error("uart_rx: unsupported parameter set");
   end

   logic w_sync;
   logic w_fall;

   uart_rx_sync u_sync (
      .clki       (clki),
      .rst_n      (rst_n),
      .i_rxd      (i_rxd),
      .o_rxd_sync (w_sync),
      .o_fall     (w_fall)
   );

   uart_rx_state_e       r_state;
   logic [TW-1:0]        r_tick;
   logic [BW-1:0]        r_bit;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] r_data;
   logic                 r_valid;
   logic                 r_ferr;
   logic                 r_perr;
   logic                 r_overrun;
   logic                 r_busy;
`ifdef UART_RX_PARITY_EN
   logic                 r_par;
`endif

   // Receive FSM, bit timing, shift register and output holding register.
   always_ff @(posedge clki or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_tick    <= {TW{1'b0}};
         r_bit     <= {BW{1'b0}};
         r_shift   <= {DATA_BITS{1'b0}};
         r_data    <= {DATA_BITS{1'b0}};
         r_valid   <= 1'b0;
         r_ferr    <= 1'b0;
         r_perr    <= 1'b0;
         r_overrun <= 1'b0;
         r_busy    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par     <= 1'b0;
`endif
      end else begin
         r_overrun <= 1'b0;
         if (r_valid && i_rx_ready) begin
            r_valid <= 1'b0;
         end
         case (r_state)
            IDLE: begin
               if (w_fall) begin
                  r_state <= START;
                  r_tick  <= {TW{1'b0}};
                  r_bit   <= {BW{1'b0}};
                  r_busy  <= 1'b1;
               end
            end
            START: begin
               // Mid-start check rejects short low glitches.
               if (r_tick == C_TICK_HALF) begin
                  r_tick <= {TW{1'b0}};
                  if (!w_sync) begin
                     r_state <= DATA;
                  end else begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_tick <= r_tick + TW'(1);
               end
            end
            DATA: begin
               if (r_tick == C_TICK_LAST) begin
                  r_tick  <= {TW{1'b0}};
                  r_shift <= {w_sync, r_shift[DATA_BITS-1:1]};
                  if (r_bit == C_BIT_LAST) begin
                     r_bit <= {BW{1'b0}};
`ifdef UART_RX_PARITY_EN
                     r_state <= PARITY;
`else
                     r_state <= STOP;
`endif
                  end else begin
                     r_bit <= r_bit + BW'(1);
                  end
               end else begin
                  r_tick <= r_tick + TW'(1);
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (r_tick == C_TICK_LAST) begin
                  r_tick  <= {TW{1'b0}};
                  r_par   <= w_sync;
                  r_state <= STOP;
               end else begin
                  r_tick <= r_tick + TW'(1);
               end
            end
`endif
            STOP: begin
               // Leave mid stop bit so a back-to-back start edge is not missed.
               if (r_tick == C_TICK_LAST) begin
                  r_tick  <= {TW{1'b0}};
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  if (r_valid && !i_rx_ready) begin
                     r_overrun <= 1'b1;
                  end else begin
                     r_data  <= r_shift;
                     r_ferr  <= ~w_sync;
                     r_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                     r_perr  <= parity_err_f(8'(r_shift), r_par, 1'(PARITY_ODD));
`else
                     r_perr  <= 1'b0;
`endif
                  end
               end else begin
                  r_tick <= r_tick + TW'(1);
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_rx_data       = r_data;
   assign o_rx_valid      = r_valid;
   assign o_rx_frame_err  = r_ferr;
   assign o_rx_parity_err = r_perr;
   assign o_rx_overrun    = r_overrun;
   assign o_rx_busy       = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected bytes, a monitor pops on handshake.
// Parity scenarios run only when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

   localparam int CPB     = 25;
   localparam int DB      = 8;
   localparam int PAR_ODD = 0;

   logic          clki = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_rxd = 1'b1;
   logic          i_rx_ready = 1'b1;
   logic [DB-1:0] o_rx_data;
   logic          o_rx_valid;
   logic          o_rx_frame_err;
   logic          o_rx_parity_err;
   logic          o_rx_overrun;
   logic          o_rx_busy;

   typedef struct {
      logic [7:0] d;
      logic       fe;
      logic       pe;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   int   ovr_cnt = 0;

   uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_ODD(PAR_ODD)) dut (
      .clki            (clki),
      .rst_n           (rst_n),
      .i_rxd           (i_rxd),
      .o_rx_data       (o_rx_data),
      .o_rx_valid      (o_rx_valid),
      .i_rx_ready      (i_rx_ready),
      .o_rx_frame_err  (o_rx_frame_err),
      .o_rx_parity_err (o_rx_parity_err),
      .o_rx_overrun    (o_rx_overrun),
      .o_rx_busy       (o_rx_busy)
   );

   always #10 clki = ~clki;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endfunction

   // Monitor: sample just after the falling edge, pop and compare on each accepted byte.
   always @(negedge clki) begin
      #1;
      if (rst_n) begin
         if (o_rx_overrun) ovr_cnt++;
         if (o_rx_valid && i_rx_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_byte actual=%0h required=none", o_rx_data);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("rx_data", 32'(o_rx_data), 32'(e.d));
               chk("frame_err", 32'(o_rx_frame_err), 32'(e.fe));
               chk("parity_err", 32'(o_rx_parity_err), 32'(e.pe));
            end
         end
      end
   end

   task automatic drive_bit(input logic b);
      i_rxd = b;
      repeat (CPB) @(negedge clki);
   endtask

   task automatic idle(input int n);
      i_rxd = 1'b1;
      repeat (n) @(negedge clki);
   endtask

   // Sends one frame; the line is left at the stop-bit level.
   task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip,
                             input logic expect_it);
      exp_t e;
      e.d  = d;
      e.fe = ~stop;
`ifdef UART_RX_PARITY_EN
      e.pe = par_flip;
`else
      e.pe = 1'b0;
`endif
      if (expect_it) exp_q.push_back(e);
      drive_bit(1'b0);
      for (int i = 0; i < DB; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit(1'(($countones(d) % 2)) ^ 1'(PAR_ODD) ^ par_flip);
`endif
      drive_bit(stop);
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(negedge clki);
         n++;
      end
      chk(name, 32'(exp_q.size()), 32'd0);
      repeat (3) @(negedge clki);
   endtask

   initial begin
      int ovr0;
      @(negedge clki);
      repeat (3) @(negedge clki);
      chk("rst_valid", 32'(o_rx_valid), 32'd0);
      chk("rst_data", 32'(o_rx_data), 32'd0);
      chk("rst_busy", 32'(o_rx_busy), 32'd0);
      chk("rst_flags", 32'({o_rx_frame_err, o_rx_parity_err, o_rx_overrun}), 32'd0);
      rst_n = 1'b1;
      idle(5);

      // Plain byte with ready held high.
      send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
      idle(10);
      wait_drain("drain_a5");

      // Short low glitch on the idle line.
      i_rxd = 1'b0;
      repeat (8) @(negedge clki);
      chk("glitch_busy_hi", 32'(o_rx_busy), 32'd1);
      i_rxd = 1'b1;
      repeat (12) @(negedge clki);
      chk("glitch_busy_lo", 32'(o_rx_busy), 32'd0);
      idle(20);
      chk("glitch_no_byte", 32'(o_rx_valid), 32'd0);

      // Stop bit low, then the line stays low.
      send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
      i_rxd = 1'b0;
      repeat (200) @(negedge clki);
      chk("stuck_low_busy", 32'(o_rx_busy), 32'd0);
      idle(10);
      wait_drain("drain_3c");

      // Overrun while the host is stalled.
      i_rx_ready = 1'b0;
      ovr0 = ovr_cnt;
      send_frame(8'h11, 1'b1, 1'b0, 1'b1);
      idle(5);
      send_frame(8'h22, 1'b1, 1'b0, 1'b0);
      idle(5);
      chk("ovr_hold_data", 32'(o_rx_data), 32'h11);
      chk("ovr_hold_valid", 32'(o_rx_valid), 32'd1);
      chk("ovr_pulses", 32'(ovr_cnt - ovr0), 32'd1);
      i_rx_ready = 1'b1;
      wait_drain("drain_ovr");

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b0, 1'b1);
      idle(5);
      send_frame(8'h07, 1'b1, 1'b1, 1'b1);
      idle(5);
      wait_drain("drain_par");
`endif

      // Reset in the middle of data bit 4 of 0xFF.
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'b1);
      i_rxd = 1'b1;
      repeat (10) @(negedge clki);
      rst_n = 1'b0;
      repeat (2) @(negedge clki);
      chk("midrst_busy", 32'(o_rx_busy), 32'd0);
      chk("midrst_valid", 32'(o_rx_valid), 32'd0);
      rst_n = 1'b1;
      idle(10);
      send_frame(8'h5A, 1'b1, 1'b0, 1'b1);
      idle(10);
      wait_drain("drain_5a");

      // Random frames with random gaps and occasional framing/parity faults.
      for (int k = 0; k < 24; k++) begin
         logic [7:0] d;
         logic       stp;
         logic       pf;
         d   = 8'($urandom_range(0, 255));
         stp = ($urandom_range(0, 5) != 0);
         pf  = ($urandom_range(0, 4) == 0);
         send_frame(d, stp, pf, 1'b1);
         idle($urandom_range(3, 20));
      end
      wait_drain("drain_rand");
      chk("final_overruns", 32'(ovr_cnt - ovr0), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
